banked_bram: RTL and testbench

BANKED_BRAM -- requirements
Module: banked_bram

---
 rtl/banked_bram.sv | 113 +++++++++++
 tb/tb_banked_bram.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/banked_bram.sv
// Multi-bank block RAM with byte-enable writes, a pipelined read port, and a
// zero-fill sweep that runs after reset or on request.
module banked_bram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_BANKS  = 4,
  parameter int OUT_REG    = 1,
  parameter int RDW_MODE   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0]  wr_bank,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH/8-1:0]       wr_be,
  input  logic                          rd_en,
  input  logic [$clog2(NUM_BANKS)-1:0]  rd_bank,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  input  logic                          clear_req,
  output logic                          ready
);
  localparam int BE    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_BANKS][DEPTH];
  logic                    wr_acc, rd_acc, rdw_hit;
  logic [DATA_WIDTH-1:0]   rd_word_d;
  logic                    vld1_q;
  logic [DATA_WIDTH-1:0]   dat1_q;

  assign ready   = (state_q == READY);
  assign wr_acc  = ready && wr_en;
  assign rd_acc  = ready && rd_en;
  assign rdw_hit = wr_acc && (wr_bank == rd_bank) && (wr_addr == rd_addr);

  // Sweep runs until the last address is zeroed; cnt_q wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        READY: if (clear_req) begin
          state_q <= CLEAR;
          cnt_q   <= '0;
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= READY;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zero-fills it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++) mem_q[b][cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE; i++)
        if (wr_be[i]) mem_q[wr_bank][wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_comb begin
    rd_word_d = mem_q[rd_bank][rd_addr];
    if (RDW_MODE != 0 && rdw_hit) begin
      for (int i = 0; i < BE; i++)
        if (wr_be[i]) rd_word_d[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Data registers load only on valid so rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) dat1_q <= rd_word_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  vld2_q;
      logic [DATA_WIDTH-1:0] dat2_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld2_q <= 1'b0;
          dat2_q <= '0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) dat2_q <= dat1_q;
        end
      end
      assign rd_valid = vld2_q;
      assign rd_data  = dat2_q;
    end else begin : g_noreg
      assign rd_valid = vld1_q;
      assign rd_data  = dat1_q;
    end
  endgenerate

endmodule

// File: tb/tb_banked_bram.sv
// Directed bench: one default instance (OUT_REG=1, RDW new-data) and one with
// OUT_REG=0, RDW old-data, both driven by the same stimulus.
module tb_banked_bram;
  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, clear_req;
  logic [1:0]  wr_bank, rd_bank;
  logic [2:0]  wr_addr, rd_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic        v0, v1, rdy0, rdy1;
  logic [63:0] d0, d1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  banked_bram dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_valid(v0), .rd_data(d0), .clear_req(clear_req),
    .ready(rdy0)
  );

  banked_bram #(.OUT_REG(0), .RDW_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_valid(v1), .rd_data(d1), .clear_req(clear_req),
    .ready(rdy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] b, input logic [2:0] a, input logic [63:0] d,
                    input logic [7:0] be);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    wr_bank = '0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_bank = '0; rd_addr = '0;
    tick(); tick();
    chk("rst_ready0", {63'd0, rdy0}, 64'd0);
    chk("rst_valid0", {63'd0, v0}, 64'd0);
    chk("rst_data0", d0, 64'd0);
    chk("rst_valid1", {63'd0, v1}, 64'd0);

    // ready must stay low for exactly 8 cycles after release
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("sweep_ready_low", {63'd0, rdy0}, 64'd0);
      tick();
    end
    chk("sweep_ready_high0", {63'd0, rdy0}, 64'd1);
    chk("sweep_ready_high1", {63'd0, rdy1}, 64'd1);

    // read bank 3 addr 7 after sweep -> 0
    rd_en = 1'b1; rd_bank = 2'd3; rd_addr = 3'd7; wr_data = 64'hDEAD; tick(); rd_en = 1'b0;
    chk("b3a7_v1_lat1", {63'd0, v1}, 64'd1);
    chk("b3a7_d1", d1, 64'd0);
    chk("b3a7_v0_not_yet", {63'd0, v0}, 64'd0);
    tick();
    chk("b3a7_v0_lat2", {63'd0, v0}, 64'd1);
    chk("b3a7_d0", d0, 64'd0);
    chk("b3a7_v1_pulse", {63'd0, v1}, 64'd0);

    // byte-enable merge
    wr(2'd2, 3'd5, 64'h1122334455667788, 8'hFF);
    wr(2'd2, 3'd5, 64'h00000000000000AA, 8'h01);
    rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 3'd5; tick(); rd_en = 1'b0;
    chk("be_d1", d1, 64'h11223344556677AA);
    tick();
    chk("be_v0", {63'd0, v0}, 64'd1);
    chk("be_d0", d0, 64'h11223344556677AA);
    chk("be_hold_d1", d1, 64'h11223344556677AA);

    // be=0 write leaves word unchanged
    wr(2'd2, 3'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("be0_d1", d1, 64'h11223344556677AA);
    tick();

    // read-during-write same location
    wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 3'd3; wr_data = 64'hFFFF; wr_be = 8'h03;
    rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 3'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_old_d1", d1, 64'd0);
    tick();
    chk("rdw_new_d0", d0, 64'hFFFF);

    // same cycle, different bank: no interaction
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 3'd3; wr_data = 64'h55; wr_be = 8'hFF;
    rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 3'd3;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("nohit_d1", d1, 64'hFFFF);
    tick();
    chk("nohit_d0", d0, 64'hFFFF);

    // back-to-back reads across banks
    for (int b = 0; b < 4; b++) wr(2'(b), 3'd0, 64'hA0 + 64'(b), 8'hFF);
    for (int b = 0; b < 4; b++) begin
      rd_en = 1'b1; rd_bank = 2'(b); rd_addr = 3'd0;
      tick();
      chk("b2b_v1", {63'd0, v1}, 64'd1);
      chk("b2b_d1", d1, 64'hA0 + 64'(b));
      if (b > 0) begin
        chk("b2b_v0", {63'd0, v0}, 64'd1);
        chk("b2b_d0", d0, 64'hA0 + 64'(b - 1));
      end
    end
    rd_en = 1'b0;
    tick();
    chk("b2b_v0_last", {63'd0, v0}, 64'd1);
    chk("b2b_d0_last", d0, 64'hA3);
    chk("b2b_v1_end", {63'd0, v1}, 64'd0);
    tick();
    chk("b2b_v0_end", {63'd0, v0}, 64'd0);

    // clear_req with a read of a nonzero word in the same cycle
    clear_req = 1'b1; rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 3'd5;
    tick();
    clear_req = 1'b0; rd_bank = 2'd0; rd_addr = 3'd0;
    chk("clr_ready_low", {63'd0, rdy0}, 64'd0);
    chk("clr_rd_d1", d1, 64'h11223344556677AA);
    tick();
    chk("clr_rd_v0", {63'd0, v0}, 64'd1);
    chk("clr_rd_d0", d0, 64'h11223344556677AA);
    chk("clr_drop_v1", {63'd0, v1}, 64'd0);
    for (int i = 2; i < 8; i++) begin
      chk("clr_ready_low_n", {63'd0, rdy0}, 64'd0);
      tick();
      chk("clr_drop_v0", {63'd0, v0}, 64'd0);
      chk("clr_drop_v1n", {63'd0, v1}, 64'd0);
    end
    rd_en = 1'b0;
    tick();
    chk("clr_ready_high", {63'd0, rdy0}, 64'd1);
    chk("clr_drop_v0_end", {63'd0, v0}, 64'd0);
    rd_en = 1'b1; rd_bank = 2'd2; rd_addr = 3'd5; tick(); rd_en = 1'b0;
    chk("post_clr_d1", d1, 64'd0);
    tick();
    chk("post_clr_v0", {63'd0, v0}, 64'd1);
    chk("post_clr_d0", d0, 64'd0);

    // reset with a read in flight
    wr(2'd1, 3'd1, 64'h77, 8'hFF);
    rd_en = 1'b1; rd_bank = 2'd1; rd_addr = 3'd1; tick(); rd_en = 1'b0;
    rst = 1'b1; tick();
    chk("rst_flush_v0", {63'd0, v0}, 64'd0);
    chk("rst_flush_d0", d0, 64'd0);
    rst = 1'b0; tick();
    chk("rst_flush_v0b", {63'd0, v0}, 64'd0);

    // reset at sweep address 4 restarts the sweep
    for (int i = 1; i < 4; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rst4_ready_low", {63'd0, rdy0}, 64'd0);
      chk("rst4_no_valid", {63'd0, v0}, 64'd0);
      tick();
    end
    chk("rst4_ready_high", {63'd0, rdy0}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
